// File: rtl/cdr_loop_controller.sv
// CDR loop controller: PI loop filter with lock/unlock/hold supervision.
// Ports: clk, reset (async low), enable, err_valid, phase_error -> phase_adj, adj_valid, locked, state.
module cdr_loop_controller #(
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int LOCK_THRESH  = 1,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              err_valid,
  input  logic signed [3:0] phase_error,
  output logic signed [5:0] phase_adj,
  output logic              adj_valid,
  output logic              locked,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam logic [3:0] LOCK_C   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_COUNT);
  localparam logic [3:0] THRESH   = 4'(LOCK_THRESH);
  localparam logic [7:0] HOLD_T   = 8'(HOLD_TIMEOUT);

  // Reset assertion is asynchronous; release is delayed two edges.
  logic [1:0] rst_sync_q;
  logic       run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run = rst_sync_q[1];

  state_e            state_q, state_d;
  logic signed [7:0] int_acc_q, int_acc_d;
  logic [3:0]        in_cnt_q, in_cnt_d;
  logic [3:0]        out_cnt_q, out_cnt_d;
  logic [7:0]        idle_cnt_q, idle_cnt_d;
  logic signed [5:0] phase_adj_q, phase_adj_d;
  logic              adj_valid_q, adj_valid_d;
  logic              locked_q, locked_d;

  logic signed [8:0] acc_sum;
  logic signed [7:0] acc_new;
  logic signed [3:0] prop;
  logic signed [8:0] adj_sum;
  logic signed [5:0] adj_sat;
  logic [3:0]        abs_err;
  logic              in_thr;
  logic [3:0]        in_inc;
  logic [3:0]        out_inc;
  logic [7:0]        idle_inc;

  always_comb begin
    acc_sum = {int_acc_q[7], int_acc_q} + {{5{phase_error[3]}}, phase_error};
    acc_new = acc_sum[7:0];
    if (acc_sum[8] != acc_sum[7])
      acc_new = acc_sum[8] ? 8'h80 : 8'h7F;
    prop = (state_q == ACQUIRE) ? phase_error : (phase_error >>> 1);
    adj_sum = {{5{prop[3]}}, prop} + {{4{acc_new[7]}}, acc_new[7:3]};
    adj_sat = adj_sum[5:0];
    if (adj_sum[8:5] != {4{adj_sum[8]}})
      adj_sat = adj_sum[8] ? 6'h20 : 6'h1F;
    // Two's complement negate in 4 unsigned bits maps -8 to 8.
    abs_err  = phase_error[3] ? (~phase_error + 4'd1) : phase_error;
    in_thr   = (abs_err <= THRESH);
    in_inc   = in_cnt_q + 4'd1;
    out_inc  = out_cnt_q + 4'd1;
    idle_inc = idle_cnt_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    int_acc_d   = int_acc_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    phase_adj_d = phase_adj_q;
    adj_valid_d = 1'b0;
    locked_d    = locked_q;
    if (!run) begin
      state_d     = IDLE;
      int_acc_d   = '0;
      in_cnt_d    = '0;
      out_cnt_d   = '0;
      idle_cnt_d  = '0;
      phase_adj_d = '0;
      locked_d    = 1'b0;
    end else if (!enable) begin
      state_d    = IDLE;
      int_acc_d  = '0;
      in_cnt_d   = '0;
      out_cnt_d  = '0;
      idle_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ACQUIRE;
        ACQUIRE: begin
          if (err_valid) begin
            int_acc_d   = acc_new;
            phase_adj_d = adj_sat;
            adj_valid_d = 1'b1;
            if (!in_thr) begin
              in_cnt_d = '0;
            end else if (in_inc == LOCK_C) begin
              state_d    = TRACK;
              locked_d   = 1'b1;
              in_cnt_d   = '0;
              out_cnt_d  = '0;
              idle_cnt_d = '0;
            end else begin
              in_cnt_d = in_inc;
            end
          end
        end
        TRACK, HOLD: begin
          if (err_valid) begin
            int_acc_d   = acc_new;
            phase_adj_d = adj_sat;
            adj_valid_d = 1'b1;
            idle_cnt_d  = '0;
            state_d     = TRACK;
            if (in_thr) begin
              out_cnt_d = '0;
            end else if (out_inc == UNLOCK_C) begin
              state_d   = ACQUIRE;
              locked_d  = 1'b0;
              in_cnt_d  = '0;
              out_cnt_d = '0;
            end else begin
              out_cnt_d = out_inc;
            end
          end else if (state_q == TRACK) begin
            if (idle_inc == HOLD_T) begin
              state_d    = HOLD;
              idle_cnt_d = '0;
            end else begin
              idle_cnt_d = idle_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      int_acc_q   <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      phase_adj_q <= '0;
      adj_valid_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      int_acc_q   <= int_acc_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      phase_adj_q <= phase_adj_d;
      adj_valid_q <= adj_valid_d;
      locked_q    <= locked_d;
    end
  end

  assign phase_adj = phase_adj_q;
  assign adj_valid = adj_valid_q;
  assign locked    = locked_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cdr_loop_controller.sv
// Bench for cdr_loop_controller: queued expected adjustments,
// integer-level loop model, directed scenarios plus random traffic.
module tb_cdr_loop_controller;

  localparam int LCNT = 8;
  localparam int UCNT = 4;
  localparam int THR  = 1;
  localparam int HTO  = 255;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              err_valid;
  logic signed [3:0] phase_error;
  logic signed [5:0] phase_adj;
  logic              adj_valid;
  logic              locked;
  logic [1:0]        state;

  cdr_loop_controller #(
    .LOCK_COUNT(LCNT),
    .UNLOCK_COUNT(UCNT),
    .LOCK_THRESH(THR),
    .HOLD_TIMEOUT(HTO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .err_valid(err_valid),
    .phase_error(phase_error),
    .phase_adj(phase_adj),
    .adj_valid(adj_valid),
    .locked(locked),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;
  bit mon_on  = 0;

  // Reference model, plain integers.
  int m_sync, m_st, m_acc, m_in, m_out, m_idle, m_lk, m_adj, m_val;
  int exp_q[$];

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_sync = 0; m_st = 0; m_acc = 0; m_in = 0; m_out = 0;
    m_idle = 0; m_lk = 0; m_adj = 0; m_val = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit rst_n, input bit en, input bit ev, input int pe);
    int prop;
    m_val = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_sync < 2) begin
      m_sync++;
      return;
    end
    if (!en) begin
      m_st = 0; m_acc = 0; m_in = 0; m_out = 0; m_idle = 0; m_lk = 0;
      return;
    end
    if (m_st == 0) begin
      m_st = 1;
      return;
    end
    if (ev) begin
      m_acc = clamp(m_acc + pe, -128, 127);
      prop = (m_st == 1) ? pe : ((pe - (pe < 0 ? 1 : 0)) / 2);
      m_adj = clamp(prop + ((m_acc - (((m_acc % 8) + 8) % 8)) / 8), -32, 31);
      m_val = 1;
      exp_q.push_back(m_adj);
      if (m_st == 1) begin
        if (iabs(pe) <= THR) begin
          m_in++;
          if (m_in == LCNT) begin
            m_st = 2; m_lk = 1; m_in = 0; m_idle = 0;
          end
        end else m_in = 0;
      end else begin
        m_idle = 0;
        m_st = 2;
        if (iabs(pe) > THR) begin
          m_out++;
          if (m_out == UCNT) begin
            m_st = 1; m_lk = 0; m_in = 0; m_out = 0;
          end
        end else m_out = 0;
      end
    end else if (m_st == 2) begin
      m_idle++;
      if (m_idle == HTO) begin
        m_st = 3; m_idle = 0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every falling edge, outputs against model and queue.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("adj_valid", int'(adj_valid), m_val);
      chk("state", int'(state), m_st);
      chk("locked", int'(locked), m_lk);
      chk("phase_adj_hold", int'(phase_adj), m_adj);
      if (adj_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_adj", 1, 0);
        end else begin
          chk("adj_queue", int'(phase_adj), exp_q.pop_front());
        end
      end
    end
  end

  // One clock: inputs held across the edge, model stepped 2 time units after.
  task automatic cyc(input bit en, input bit ev, input int pe);
    enable = en;
    err_valid = ev;
    phase_error = 4'(pe);
    @(posedge clk);
    #2;
    model_edge(reset, en, ev, pe);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    enable = 1'b0;
    err_valid = 1'b0;
    cyc(0, 0, 0);
    reset = 1'b1;
  endtask

  task automatic reach_track();
    do_reset();
    repeat (3) cyc(1, 0, 0);
    repeat (LCNT) cyc(1, 1, 0);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    err_valid = 1'b0;
    phase_error = '0;
    model_reset();
    #1 reset = 1'b0;
    @(posedge clk);
    #2;
    mon_on = 1;
    cyc(0, 0, 0);
    reset = 1'b1;

    // Idle enabled loop with no samples.
    repeat (4) cyc(1, 0, 0);
    chk("acq_state", int'(state), 1);
    chk("acq_locked", int'(locked), 0);
    chk("acq_adj", int'(phase_adj), 0);

    // Eight zero samples lock the loop.
    repeat (LCNT) cyc(1, 1, 0);
    chk("lock_state", int'(state), 2);
    chk("lock_locked", int'(locked), 1);

    // Unlock burst with an in-threshold sample in between.
    repeat (3) cyc(1, 1, -8);
    chk("burst1_locked", int'(locked), 1);
    cyc(1, 1, 0);
    repeat (3) cyc(1, 1, -8);
    chk("burst2_pre_locked", int'(locked), 1);
    cyc(1, 1, -8);
    chk("unlock_state", int'(state), 1);
    chk("unlock_locked", int'(locked), 0);

    // Integrator saturation in ACQUIRE.
    do_reset();
    repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 7);
    chk("first_p7", int'(phase_adj), 7);
    repeat (20) cyc(1, 1, 7);
    chk("sat_p7", int'(phase_adj), 22);
    chk("sat_state", int'(state), 1);

    // Hold entry after idle timeout and exit on the next sample.
    reach_track();
    repeat (HTO - 1) cyc(1, 0, 0);
    chk("pre_hold_state", int'(state), 2);
    cyc(1, 0, 0);
    chk("hold_state", int'(state), 3);
    chk("hold_locked", int'(locked), 1);
    repeat (5) cyc(1, 0, 0);
    chk("hold_no_adj", int'(adj_valid), 0);
    cyc(1, 1, 2);
    chk("hold_exit_state", int'(state), 2);
    chk("hold_exit_valid", int'(adj_valid), 1);

    // Sample coinciding with enable falling is dropped.
    repeat (4) cyc(1, 1, 5);
    cyc(0, 1, 5);
    chk("drop_valid", int'(adj_valid), 0);
    chk("drop_state", int'(state), 0);
    chk("drop_locked", int'(locked), 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("drop_acc_zero", int'(phase_adj), 0);

    // Reset during a sample: no pulse afterwards.
    enable = 1'b1;
    err_valid = 1'b1;
    phase_error = 4'sd3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_adj", int'(phase_adj), 0);
    cyc(1, 1, 3);
    reset = 1'b1;
    cyc(1, 1, 3);
    cyc(1, 1, 3);
    chk("sync_rel_state", int'(state), 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit en, ev;
      int pe;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        en = ($urandom_range(0, 79) != 0);
        ev = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 3) == 0) pe = int'($urandom_range(0, 15)) - 8;
        else pe = int'($urandom_range(0, 2)) - 1;
        cyc(en, ev, pe);
      end
    end

    repeat (2) cyc(1, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/cdr_loop_controller.md
CDR_LOOP_CONTROLLER -- requirements
Module: cdr_loop_controller

Interface
REQ-001 Parameter LOCK_COUNT, default 8: consecutive in-threshold samples required to declare lock (range 1-15).
REQ-002 Parameter UNLOCK_COUNT, default 4: consecutive out-of-threshold samples required to drop lock (range 1-15).
REQ-003 Parameter LOCK_THRESH, default 1: largest |phase_error| counted as in-threshold (range 0-8).
REQ-004 Parameter HOLD_TIMEOUT, default 255: idle cycles without err_valid in TRACK before HOLD is entered (range 1-255).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  loop enable; low forces IDLE.
REQ-008 err_valid  input  1  single-cycle strobe; phase_error is valid on the same cycle.
REQ-009 phase_error  input  4  signed phase detector error, -8..+7.
REQ-010 phase_adj  output  6  signed phase correction to the recovered-clock generator, -32..+31.
REQ-011 adj_valid  output  1  single-cycle strobe; phase_adj is valid on the same cycle.
REQ-012 locked  output  1  loop lock indicator.
REQ-013 state  output  2  FSM state: 0 IDLE, 1 ACQUIRE, 2 TRACK, 3 HOLD.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, ACQUIRE, TRACK and HOLD; all transitions occur on the rising clk edge.
REQ-015 enable low SHALL force IDLE on the next edge from any state, clear int_acc and both run counters, and drive locked=0 and adj_valid=0.
REQ-016 IDLE SHALL go to ACQUIRE on the first edge with enable=1, and SHALL ignore err_valid on that cycle.
REQ-017 A "sample" SHALL be any cycle with err_valid=1 in ACQUIRE, TRACK or HOLD.
REQ-018 Each sample SHALL update int_acc, a signed 8-bit integrator: int_acc <= sat8(int_acc + phase_error), clamped to -128..+127.
REQ-019 The proportional term SHALL be prop = phase_error in ACQUIRE, and prop = phase_error >>> 1 (arithmetic shift; -1 gives -1) in TRACK and HOLD.
REQ-020 At the edge that ends a sample cycle, the block SHALL register phase_adj <= sat6(prop + (int_acc_new >>> 3)) using the updated integrator; the sum SHALL be computed at 9 bits and clamped to -32..+31.
REQ-021 adj_valid SHALL pulse high for exactly one cycle, one cycle after each sample (latency 1); phase_adj SHALL hold its last value between samples.
REQ-022 A sample is in-threshold when |phase_error| <= LOCK_THRESH; |-8| SHALL evaluate as 8 without overflow.
REQ-023 In ACQUIRE, in_cnt SHALL increment on each in-threshold sample and clear on each out-of-threshold sample; the sample that brings in_cnt to LOCK_COUNT SHALL move the FSM to TRACK, set locked=1 and clear in_cnt on the same edge.
REQ-024 In TRACK, out_cnt SHALL increment on each out-of-threshold sample and clear on each in-threshold sample; reaching UNLOCK_COUNT SHALL move the FSM to ACQUIRE, clear locked and both counters, and keep int_acc.
REQ-025 In TRACK, idle_cnt (8-bit) SHALL count cycles without err_valid and clear on each sample; when idle_cnt reaches HOLD_TIMEOUT, the FSM SHALL go to HOLD with locked held at 1.
REQ-026 In HOLD, no adjustment SHALL be issued until the next sample; that sample SHALL be processed under TRACK rules (REQ-019/020/024) and SHALL return the FSM to TRACK on the same edge.
REQ-027 A sample that coincides with enable falling SHALL be discarded: no adj_valid and no integrator update.
REQ-028 The FSM SHALL never remain in an undefined encoding; it SHALL recover to IDLE on the next edge.

Reset
REQ-029 While reset=0: state=IDLE, int_acc=0, in_cnt=out_cnt=idle_cnt=0, phase_adj=0, adj_valid=0, locked=0, taking effect asynchronously.
REQ-030 Reset deassertion SHALL be synchronised internally, so the first state change occurs no earlier than the second clk edge after release.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight sample with no adj_valid pulse.

Verification
REQ-032 Reset and enable=1 with no samples -> state=ACQUIRE, all outputs 0, no adj_valid.
REQ-033 8 samples of phase_error=0 -> 8 adj_valid pulses with phase_adj=0; locked=1 and state=TRACK one cycle after the 8th sample.
REQ-034 From reset, one sample of +7 in ACQUIRE -> phase_adj=+7; then 20 further samples of +7 -> int_acc saturates at 127 and phase_adj=+22.
REQ-035 In TRACK, 3 samples of -8 then one sample of 0 then 4 samples of -8 -> lock is held through the first burst; locked=0 and state=ACQUIRE one cycle after the 4th sample of the second burst.
REQ-036 In TRACK, 255 cycles without err_valid -> state=HOLD with locked=1; the next sample of +2 -> state=TRACK and adj_valid pulses.
REQ-037 enable dropped on the same cycle as a sample -> no adj_valid pulse, state=IDLE, int_acc=0 and locked=0 on the next edge.
